// File: rtl/arrow_spawner_if.sv
// Connection bundle between the arrow wave sequencer, the raster/arrow sprite
// side and the game FSM.
interface arrow_spawner_if;
    logic        start_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        hit_player_in;
    logic        valid_out;
    logic [1:0]  direction_out;
    logic        inversed_out;
    logic [2:0]  speed_out;
    logic [7:0]  arrows_left_out;
    logic [7:0]  hits_out;
    logic        busy_out;
    logic        done_out;

    modport master (
        input  start_in, hcount_in, vcount_in, hit_player_in,
        output valid_out, direction_out, inversed_out, speed_out,
               arrows_left_out, hits_out, busy_out, done_out
    );

    modport slave (
        output start_in, hcount_in, vcount_in, hit_player_in,
        input  valid_out, direction_out, inversed_out, speed_out,
               arrows_left_out, hits_out, busy_out, done_out
    );
endinterface

// File: rtl/arrow_spawner.sv
// Wave sequencer feeding the arrow sprite: paces NUM_ARROWS arrows per wave on
// frame ticks, picks LFSR directions and counts player hits.
module arrow_spawner #(
    parameter int          NUM_ARROWS      = 16,
    parameter int          LIFETIME_FRAMES = 100,
    parameter int          GAP_FRAMES      = 30,
    parameter logic [2:0]  SPEED           = 3'd4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic             clk,
    input logic             rst,
    arrow_spawner_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GAP    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int CNT_MAX = (LIFETIME_FRAMES > GAP_FRAMES) ? LIFETIME_FRAMES : GAP_FRAMES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_FRAMES - 1);
    localparam logic [CNT_W-1:0] LIFE_LAST = CNT_W'(LIFETIME_FRAMES - 1);
    localparam logic [7:0]       NUM_INIT  = 8'(NUM_ARROWS);
    localparam bit               EMPTY_WAVE = (NUM_ARROWS == 0);

    logic [1:0]       state,     state_nxt;
    logic [CNT_W-1:0] frame_cnt, cnt_nxt;
    logic [15:0]      lfsr;
    logic             lfsr_fb;
    logic             raw, raw_q, tick;
    logic             valid_q,   valid_nxt;
    logic [1:0]       dir_q,     dir_nxt;
    logic             inv_q,     inv_nxt;
    logic [7:0]       left_q,    left_nxt;
    logic [7:0]       hits_q,    hits_nxt;
    logic             busy_q,    busy_nxt;
    logic             done_q,    done_nxt;
    logic             clear_hits;

    // One tick per frame: only the first cycle of a held (0,0) position counts.
    assign raw     = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
    assign tick    = raw && !raw_q;
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    assign bus.valid_out       = valid_q;
    assign bus.direction_out   = dir_q;
    assign bus.inversed_out    = inv_q;
    assign bus.speed_out       = SPEED;
    assign bus.arrows_left_out = left_q;
    assign bus.hits_out        = hits_q;
    assign bus.busy_out        = busy_q;
    assign bus.done_out        = done_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = frame_cnt;
        valid_nxt  = valid_q;
        dir_nxt    = dir_q;
        inv_nxt    = inv_q;
        left_nxt   = left_q;
        busy_nxt   = busy_q;
        done_nxt   = done_q;
        clear_hits = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start_in) begin
                    clear_hits = 1'b1;
                    cnt_nxt    = '0;
                    if (EMPTY_WAVE) begin
                        state_nxt = S_DONE;
                        left_nxt  = 8'd0;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                        left_nxt  = NUM_INIT;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                    end
                end
            end

            S_GAP: begin
                if (tick) begin
                    if (frame_cnt == GAP_LAST) begin
                        state_nxt = S_ACTIVE;
                        cnt_nxt   = '0;
                        valid_nxt = 1'b1;
                        dir_nxt   = lfsr[1:0];
                        inv_nxt   = lfsr[2];
                    end else begin
                        cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end

            S_ACTIVE: begin
                // The last arrow of the wave goes straight to DONE, skipping its trailing gap.
                if (tick) begin
                    if (frame_cnt == LIFE_LAST) begin
                        valid_nxt = 1'b0;
                        left_nxt  = left_q - 8'd1;
                        cnt_nxt   = '0;
                        if (left_q == 8'd1) begin
                            state_nxt = S_DONE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_GAP;
                        end
                    end else begin
                        cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    // Hits are gated by the registered valid, so the end-of-lifetime cycle still counts.
    always_comb begin
        hits_nxt = hits_q;
        if (clear_hits) begin
            hits_nxt = 8'd0;
        end else if (valid_q && bus.hit_player_in && (hits_q != 8'hFF)) begin
            hits_nxt = hits_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            frame_cnt <= '0;
            lfsr      <= LFSR_SEED;
            raw_q     <= 1'b0;
            valid_q   <= 1'b0;
            dir_q     <= 2'd0;
            inv_q     <= 1'b0;
            left_q    <= 8'd0;
            hits_q    <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= cnt_nxt;
            lfsr      <= {lfsr_fb, lfsr[15:1]};
            raw_q     <= raw;
            valid_q   <= valid_nxt;
            dir_q     <= dir_nxt;
            inv_q     <= inv_nxt;
            left_q    <= left_nxt;
            hits_q    <= hits_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
        end
    end

endmodule
